// File: rtl/lsu_mem_requester_if.sv
// Request/response and memory-controller signal bundle for the LSU memory requester.
// The requester (initiator of controller accesses) uses the master view; the pipeline
// and controller models on the other side use the slave view.
interface lsu_mem_requester_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
);
  // Pipeline request side
  logic                  req_valid;
  logic                  req_write;
  logic [2:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  busy;
  // Pipeline response side
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  // Memory controller side
  logic                  mem_write;
  logic [2:0]            mem_size;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    input  req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, busy, rsp_valid, rsp_rdata, rsp_err,
           mem_write, mem_size, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, busy, rsp_valid, rsp_rdata, rsp_err,
           mem_write, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_requester.sv
// LSU memory requester: takes one load/store from the MEM stage, screens size and
// alignment, presents it to the memory controller until MemReady, and returns the
// size-extracted load data (or an error) as a one-cycle response pulse.
module lsu_mem_requester #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 17,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_mem_requester_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] SIZE_NONE = 3'b111;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  mem_write_r;
  logic [2:0]            mem_size_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic                  rsp_err_r;
  logic                  req_legal;

  // Stores only allow byte/half/word; unsigned sizes exist for loads only.
  // Halves need even addresses, words need 4-byte aligned addresses.
  function automatic logic is_legal(input logic wr, input logic [2:0] sz, input logic [1:0] a);
    logic ok_size;
    logic ok_align;
    if (wr) ok_size = (sz == 3'b000) || (sz == 3'b001) || (sz == 3'b010);
    else    ok_size = (sz == 3'b000) || (sz == 3'b001) || (sz == 3'b010) ||
                      (sz == 3'b100) || (sz == 3'b101);
    case (sz[1:0])
      2'b01:   ok_align = ~a[0];
      2'b10:   ok_align = (a == 2'b00);
      default: ok_align = 1'b1;
    endcase
    return ok_size && ok_align;
  endfunction

  // Store data is presented right-justified with the unused upper lanes zeroed.
  function automatic logic [DATA_WIDTH-1:0] store_format(input logic [2:0] sz,
                                                         input logic [DATA_WIDTH-1:0] w);
    case (sz[1:0])
      2'b00:   return {24'b0, w[7:0]};
      2'b01:   return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // The controller returns sub-word data right-justified; extend it per funct3.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] sz,
                                                        input logic [DATA_WIDTH-1:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[7:0];
    h = rd[15:0];
    case (sz)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, rd[7:0]};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, rd[15:0]};
      default: return rd;
    endcase
  endfunction

  assign req_legal = is_legal(bus.req_write, bus.req_size, bus.req_addr[1:0]);

  // Request FSM with registered controller and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      mem_write_r <= 1'b0;
      mem_size_r  <= SIZE_NONE;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (req_legal) begin
              state       <= REQ;
              tmo_cnt     <= '0;
              mem_write_r <= bus.req_write;
              mem_size_r  <= bus.req_size;
              mem_addr_r  <= bus.req_addr;
              mem_wdata_r <= store_format(bus.req_size, bus.req_wdata);
            end else begin
              // Rejected without touching the controller
              state       <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= '0;
            end
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            state       <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= mem_write_r ? '0 : load_extend(mem_size_r, bus.mem_rdata);
            mem_size_r  <= SIZE_NONE;
            mem_write_r <= 1'b0;
          end else if (tmo_cnt == CNT_LAST) begin
            state       <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= '0;
            mem_size_r  <= SIZE_NONE;
            mem_write_r <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_err_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.mem_write = mem_write_r;
  assign bus.mem_size  = mem_size_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_requester.sv
// Directed bench for lsu_mem_requester: loads, stores, illegal requests, timeout,
// mid-access reset and requests issued while busy.
module tb_lsu_mem_requester;

  localparam int DW  = 32;
  localparam int AW  = 17;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  lsu_mem_requester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  lsu_mem_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; leaves time at 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns just after the accepting edge.
  task automatic issue(input logic wr, input logic [2:0] sz, input logic [AW-1:0] a,
                       input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Load with ready in the first REQ cycle, checking the returned data.
  task automatic do_load(input string tag, input logic [2:0] sz, input logic [AW-1:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd;
    issue(1'b0, sz, a, 32'h0);
    tick();
    chk({tag, "_vld"}, bus.rsp_valid, 1'b1);
    chk({tag, "_data"}, bus.rsp_rdata, exp);
    chk({tag, "_err"}, bus.rsp_err, 1'b0);
    tick();
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_size", bus.mem_size, 3'b111);
    chk("rst_write", bus.mem_write, 1'b0);
    chk("rst_vld", bus.rsp_valid, 1'b0);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: lw with immediate ready
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    issue(1'b0, 3'b010, 17'h10000, 32'h0);
    chk("t1_size", bus.mem_size, 3'b010);
    chk("t1_write", bus.mem_write, 1'b0);
    chk("t1_addr", bus.mem_addr, 32'h10000);
    chk("t1_busy", bus.busy, 1'b1);
    chk("t1_rdy", bus.req_ready, 1'b0);
    chk("t1_vld0", bus.rsp_valid, 1'b0);
    tick();
    chk("t1_vld", bus.rsp_valid, 1'b1);
    chk("t1_data", bus.rsp_rdata, 32'hDEADBEEF);
    chk("t1_err", bus.rsp_err, 1'b0);
    chk("t1_size_end", bus.mem_size, 3'b111);
    tick();
    chk("t1_vld_clr", bus.rsp_valid, 1'b0);
    chk("t1_data_hold", bus.rsp_rdata, 32'hDEADBEEF);
    chk("t1_idle", bus.req_ready, 1'b1);
    bus.mem_ready = 1'b0;

    // 2: sub-word load extension
    do_load("t2_lb", 3'b000, 17'h10003, 32'h000000F0, 32'hFFFFFFF0);
    do_load("t2_lbu", 3'b100, 17'h10003, 32'h000000F0, 32'h000000F0);
    do_load("t2_lh", 3'b001, 17'h10002, 32'h00008001, 32'hFFFF8001);
    do_load("t2_lhu", 3'b101, 17'h10002, 32'hFFFF8001, 32'h00008001);

    // 3: sh held for five REQ cycles
    bus.mem_rdata = 32'hAAAAAAAA;
    issue(1'b1, 3'b001, 17'h10002, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      chk("t3_write", bus.mem_write, 1'b1);
      chk("t3_size", bus.mem_size, 3'b001);
      chk("t3_wdata", bus.mem_wdata, 32'h00005678);
      chk("t3_addr", bus.mem_addr, 32'h10002);
      chk("t3_busy", bus.busy, 1'b1);
      chk("t3_vld0", bus.rsp_valid, 1'b0);
      if (i == 4) bus.mem_ready = 1'b1;
      tick();
    end
    chk("t3_vld", bus.rsp_valid, 1'b1);
    chk("t3_data", bus.rsp_rdata, 32'h0);
    chk("t3_err", bus.rsp_err, 1'b0);
    chk("t3_write_end", bus.mem_write, 1'b0);
    chk("t3_size_end", bus.mem_size, 3'b111);
    tick();
    bus.mem_ready = 1'b0;

    // 4: misaligned lw and illegal store size
    bus.mem_ready = 1'b1;
    issue(1'b0, 3'b010, 17'h10001, 32'h0);
    chk("t4a_vld", bus.rsp_valid, 1'b1);
    chk("t4a_err", bus.rsp_err, 1'b1);
    chk("t4a_data", bus.rsp_rdata, 32'h0);
    chk("t4a_size", bus.mem_size, 3'b111);
    tick();
    chk("t4a_vld_clr", bus.rsp_valid, 1'b0);
    chk("t4a_err_clr", bus.rsp_err, 1'b0);
    chk("t4a_size2", bus.mem_size, 3'b111);
    issue(1'b1, 3'b100, 17'h10000, 32'h55);
    chk("t4b_vld", bus.rsp_valid, 1'b1);
    chk("t4b_err", bus.rsp_err, 1'b1);
    chk("t4b_size", bus.mem_size, 3'b111);
    chk("t4b_write", bus.mem_write, 1'b0);
    tick();
    chk("t4b_size2", bus.mem_size, 3'b111);
    bus.mem_ready = 1'b0;

    // 5: timeout
    issue(1'b0, 3'b010, 17'h10004, 32'h0);
    chk("t5_size", bus.mem_size, 3'b010);
    n = 0;
    while (!bus.rsp_valid && n < 4 * TMO) begin
      tick();
      n++;
    end
    chk("t5_latency", n, TMO);
    chk("t5_err", bus.rsp_err, 1'b1);
    chk("t5_data", bus.rsp_rdata, 32'h0);
    chk("t5_size_end", bus.mem_size, 3'b111);
    tick();
    do_load("t5_next", 3'b010, 17'h10008, 32'h01234567, 32'h01234567);

    // 6: asynchronous reset in the middle of a request
    issue(1'b1, 3'b010, 17'h1000C, 32'hCAFEF00D);
    tick();
    chk("t6_pre_size", bus.mem_size, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_size", bus.mem_size, 3'b111);
    chk("t6_write", bus.mem_write, 1'b0);
    chk("t6_addr", bus.mem_addr, 32'h0);
    chk("t6_wdata", bus.mem_wdata, 32'h0);
    chk("t6_data", bus.rsp_rdata, 32'h0);
    chk("t6_vld", bus.rsp_valid, 1'b0);
    chk("t6_busy", bus.busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    do_load("t6_lw", 3'b010, 17'h10000, 32'hDEADBEEF, 32'hDEADBEEF);

    // 6b: requests presented while busy are dropped
    issue(1'b0, 3'b010, 17'h10010, 32'h0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 17'h10020;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) bus.mem_ready = 1'b1;
      tick();
      if (bus.rsp_valid) pulses++;
      if (bus.req_ready) bus.req_valid = 1'b0;
    end
    chk("t6b_pulses", pulses, 1);
    chk("t6b_addr", bus.mem_addr, 32'h10010);
    chk("t6b_idle", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
